// File: rtl/lifo_multi.sv
// ---------------------------------------------------------------------------
// lifo_multi
//
// Multi-channel LIFO stack. CHANNELS independent stacks of DEPTH words share
// one push/pop/flush port steered by 'ch'. Each stack is a circular buffer
// with a top pointer (next free slot) and an occupancy counter, so a push on
// a full stack can optionally overwrite the oldest entry.
//
// Configuration macro:
//   LIFO_MULTI_OVERWRITE_EN  defined   : push on full overwrites oldest entry
//                            undefined : push on full is dropped, err pulses
//
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous active-low reset
//   ch       in   channel addressed this cycle
//   push     in   push datain onto stack ch
//   pop      in   pop top of stack ch
//   flush    in   empty stack ch (highest priority)
//   datain   in   word to push
//   dataout  out  last popped word, held until the next successful pop
//   val      out  one-cycle pulse: dataout updated
//   err      out  one-cycle pulse: illegal operation
//   full     out  per-channel full flags
//   empty    out  per-channel empty flags
//   count    out  occupancy of channel ch (combinational)
// ---------------------------------------------------------------------------
module lifo_multi #(
    parameter int DATA_W   = 10,
    parameter int DEPTH    = 6,
    parameter int CHANNELS = 4,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CH_W-1:0]     ch,
    input  logic                push,
    input  logic                pop,
    input  logic                flush,
    input  logic [DATA_W-1:0]   datain,
    output logic [DATA_W-1:0]   dataout,
    output logic                val,
    output logic                err,
    output logic [CHANNELS-1:0] full,
    output logic [CHANNELS-1:0] empty,
    output logic [CNT_W-1:0]    count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [CHANNELS][DEPTH];
    logic [PTR_W-1:0]  top [CHANNELS];
    logic [CNT_W-1:0]  cnt [CHANNELS];

    logic              ch_ok;
    logic [CH_W-1:0]   sel;

    logic [CNT_W-1:0]  cur_cnt;
    logic [PTR_W-1:0]  cur_top;
    logic [PTR_W-1:0]  top_inc;
    logic [PTR_W-1:0]  top_dec;
    logic              is_full;
    logic              is_empty;

    logic              upd;
    logic [CNT_W-1:0]  nxt_cnt;
    logic [PTR_W-1:0]  nxt_top;
    logic              mem_we;
    logic [PTR_W-1:0]  mem_addr;
    logic [DATA_W-1:0] nxt_dout;
    logic              set_val;
    logic              set_err;

    // When CHANNELS is not a power of two some ch codes have no stack behind
    // them; those are steered to channel 0 for reads but never allowed to
    // change state.
    generate
        if ((2 ** CH_W) > CHANNELS) begin : g_range_check
            assign ch_ok = ({1'b0, ch} < (CH_W + 1)'(CHANNELS));
            assign sel   = ch_ok ? ch : '0;
        end else begin : g_no_range_check
            assign ch_ok = 1'b1;
            assign sel   = ch;
        end
    endgenerate

    assign count = ch_ok ? cnt[sel] : '0;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            full[i]  = (cnt[i] == CNT_W'(DEPTH));
            empty[i] = (cnt[i] == '0);
        end
    end

    // Decode the single request of this cycle into next-state values for
    // the addressed channel. Pointer wrap uses explicit compares because
    // DEPTH need not be a power of two.
    always_comb begin
        cur_cnt  = cnt[sel];
        cur_top  = top[sel];
        top_inc  = (cur_top == PTR_W'(DEPTH - 1)) ? '0 : cur_top + PTR_W'(1);
        top_dec  = (cur_top == '0) ? PTR_W'(DEPTH - 1) : cur_top - PTR_W'(1);
        is_full  = (cur_cnt == CNT_W'(DEPTH));
        is_empty = (cur_cnt == '0);

        upd      = 1'b0;
        nxt_cnt  = cur_cnt;
        nxt_top  = cur_top;
        mem_we   = 1'b0;
        mem_addr = cur_top;
        nxt_dout = dataout;
        set_val  = 1'b0;
        set_err  = 1'b0;

        if (!ch_ok) begin
            set_err = push | pop;
        end else if (flush) begin
            // Top pointer is deliberately left where it is.
            upd     = 1'b1;
            nxt_cnt = '0;
        end else if (push && pop) begin
            set_val = 1'b1;
            if (is_empty) begin
                nxt_dout = datain;
            end else begin
                nxt_dout = mem[sel][top_dec];
                mem_we   = 1'b1;
                mem_addr = top_dec;
            end
        end else if (push) begin
            if (!is_full) begin
                upd      = 1'b1;
                mem_we   = 1'b1;
                nxt_top  = top_inc;
                nxt_cnt  = cur_cnt + CNT_W'(1);
            end else begin
`ifdef LIFO_MULTI_OVERWRITE_EN
                // The oldest entry sits at slot top when full; overwrite it
                // and advance so the stack keeps the newest DEPTH words.
                upd      = 1'b1;
                mem_we   = 1'b1;
                nxt_top  = top_inc;
`else
                set_err  = 1'b1;
`endif
            end
        end else if (pop) begin
            if (!is_empty) begin
                upd      = 1'b1;
                nxt_dout = mem[sel][top_dec];
                nxt_top  = top_dec;
                nxt_cnt  = cur_cnt - CNT_W'(1);
                set_val  = 1'b1;
            end else begin
                set_err  = 1'b1;
            end
        end
    end

    // Control state: reset wins over any request in the same cycle.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= '0;
                top[i] <= '0;
            end
            dataout <= '0;
            val     <= 1'b0;
            err     <= 1'b0;
        end else begin
            val     <= set_val;
            err     <= set_err;
            dataout <= nxt_dout;
            if (upd) begin
                cnt[sel] <= nxt_cnt;
                top[sel] <= nxt_top;
            end
        end
    end

    // Storage is not cleared by reset, but a write is still aborted by it.
    always_ff @(posedge clock) begin
        if (reset && mem_we) begin
            mem[sel][mem_addr] <= datain;
        end
    end

endmodule

// File: tb/tb_lifo_multi.sv
// ---------------------------------------------------------------------------
// tb_lifo_multi
//
// Self-checking bench for lifo_multi (default parameters). A table of
// directed vectors carries hand-computed expectations, a hand-written
// sequence covers reset mid-operation, and a randomized phase compares the
// DUT against a queue-based stack model every cycle.
// ---------------------------------------------------------------------------
module tb_lifo_multi;

    localparam int DATA_W   = 10;
    localparam int DEPTH    = 6;
    localparam int CHANNELS = 4;
    localparam int CH_W     = 2;
    localparam int CNT_W    = 3;

`ifdef LIFO_MULTI_OVERWRITE_EN
    localparam bit OVW = 1'b1;
`else
    localparam bit OVW = 1'b0;
`endif

    logic                clock;
    logic                reset;
    logic [CH_W-1:0]     ch;
    logic                push;
    logic                pop;
    logic                flush;
    logic [DATA_W-1:0]   datain;
    logic [DATA_W-1:0]   dataout;
    logic                val;
    logic                err;
    logic [CHANNELS-1:0] full;
    logic [CHANNELS-1:0] empty;
    logic [CNT_W-1:0]    count;

    lifo_multi #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .CHANNELS(CHANNELS)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .ch     (ch),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .datain (datain),
        .dataout(dataout),
        .val    (val),
        .err    (err),
        .full   (full),
        .empty  (empty),
        .count  (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one queue per channel, back of the queue is the top.
    logic [DATA_W-1:0] mq [CHANNELS][$];
    logic [DATA_W-1:0] m_dout = '0;
    bit                m_val  = 1'b0;
    bit                m_err  = 1'b0;

    typedef struct {
        int                ch;
        bit                push;
        bit                pop;
        bit                flush;
        logic [DATA_W-1:0] din;
        bit                e_val;
        bit                e_err;
        logic [DATA_W-1:0] e_dout;
        int                e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int c, input bit pu, input bit po, input bit fl,
                       input logic [DATA_W-1:0] d, input bit ev, input bit ee,
                       input logic [DATA_W-1:0] edo, input int ec);
        vec_t v;
        v.ch = c; v.push = pu; v.pop = po; v.flush = fl; v.din = d;
        v.e_val = ev; v.e_err = ee; v.e_dout = edo; v.e_cnt = ec;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Advance the model by one request, written directly from the stack
    // rules rather than from any pointer arithmetic.
    task automatic modelStep(input int c, input bit pu, input bit po,
                             input bit fl, input logic [DATA_W-1:0] d,
                             input bit rst_n);
        int n;
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) mq[i].delete();
            m_dout = '0; m_val = 1'b0; m_err = 1'b0;
            return;
        end
        m_val = 1'b0; m_err = 1'b0;
        n = mq[c].size();
        if (fl) begin
            mq[c].delete();
        end else if (pu && po) begin
            m_val = 1'b1;
            if (n > 0) begin
                m_dout = mq[c][n-1];
                mq[c][n-1] = d;
            end else begin
                m_dout = d;
            end
        end else if (pu) begin
            if (n < DEPTH) mq[c].push_back(d);
            else if (OVW) begin
                void'(mq[c].pop_front());
                mq[c].push_back(d);
            end else m_err = 1'b1;
        end else if (po) begin
            if (n > 0) begin
                m_dout = mq[c].pop_back();
                m_val = 1'b1;
            end else m_err = 1'b1;
        end
    endtask

    task automatic checkModel(input string tag);
        logic [CHANNELS-1:0] ef, ee;
        for (int i = 0; i < CHANNELS; i++) begin
            ef[i] = (mq[i].size() == DEPTH);
            ee[i] = (mq[i].size() == 0);
        end
        checkOutput({tag, " model val"},   32'(val),     32'(m_val));
        checkOutput({tag, " model err"},   32'(err),     32'(m_err));
        checkOutput({tag, " model dout"},  32'(dataout), 32'(m_dout));
        checkOutput({tag, " model full"},  32'(full),    32'(ef));
        checkOutput({tag, " model empty"}, 32'(empty),   32'(ee));
        checkOutput({tag, " model count"}, 32'(count),   32'(mq[ch].size()));
    endtask

    // Called at a negedge: drive inputs, let one posedge happen, return at
    // the following negedge with the model advanced to match.
    task automatic applyStimulus(input int c, input bit pu, input bit po,
                                 input bit fl, input logic [DATA_W-1:0] d,
                                 input bit rst_n);
        ch = CH_W'(c); push = pu; pop = po; flush = fl; datain = d;
        reset = rst_n;
        @(posedge clock);
        @(negedge clock);
        modelStep(c, pu, po, fl, d, rst_n);
    endtask

    logic [DATA_W-1:0] pops_plain [6];
    logic [DATA_W-1:0] pops_ovw   [6];
    logic [DATA_W-1:0] pushes     [7];
    logic [DATA_W-1:0] last1;

    initial begin
        reset = 1'b0; ch = '0; push = 1'b0; pop = 1'b0; flush = 1'b0;
        datain = '0;
        @(negedge clock);

        // Reset state
        applyStimulus(0, 1, 1, 0, 10'h3FF, 0);
        applyStimulus(0, 0, 0, 0, '0, 0);
        checkOutput("reset val",   32'(val),     32'd0);
        checkOutput("reset err",   32'(err),     32'd0);
        checkOutput("reset dout",  32'(dataout), 32'd0);
        checkOutput("reset empty", 32'(empty),   32'hF);
        checkOutput("reset full",  32'(full),    32'h0);
        checkOutput("reset count", 32'(count),   32'd0);

        // Directed table
        pushes     = '{10'h0AA, 10'h0BB, 10'h0CC, 10'h0DD, 10'h0EE, 10'h0FF, 10'h0AB};
        pops_plain = '{10'h0FF, 10'h0EE, 10'h0DD, 10'h0CC, 10'h0BB, 10'h0AA};
        pops_ovw   = '{10'h0AB, 10'h0FF, 10'h0EE, 10'h0DD, 10'h0CC, 10'h0BB};
        last1      = OVW ? 10'h0BB : 10'h0AA;

        add(0, 1, 0, 0, 10'h011, 0, 0, 10'h000, 1);
        add(0, 1, 0, 0, 10'h022, 0, 0, 10'h000, 2);
        add(0, 0, 1, 0, 10'h000, 1, 0, 10'h022, 1);
        add(0, 0, 1, 0, 10'h000, 1, 0, 10'h011, 0);
        for (int k = 0; k < 6; k++)
            add(1, 1, 0, 0, pushes[k], 0, 0, 10'h011, k + 1);
        add(1, 1, 0, 0, pushes[6], 0, !OVW, 10'h011, 6);
        for (int k = 0; k < 6; k++)
            add(1, 0, 1, 0, '0, 1, 0, OVW ? pops_ovw[k] : pops_plain[k], 5 - k);
        add(2, 1, 0, 0, 10'h044, 0, 0, last1,    1);
        add(2, 1, 1, 0, 10'h055, 1, 0, 10'h044,  1);
        add(2, 0, 1, 0, 10'h000, 1, 0, 10'h055,  0);
        add(0, 1, 0, 0, 10'h033, 0, 0, 10'h055,  1);
        add(3, 1, 0, 0, 10'h066, 0, 0, 10'h055,  1);
        add(0, 0, 0, 1, 10'h000, 0, 0, 10'h055,  0);
        add(0, 0, 1, 0, 10'h000, 0, 1, 10'h055,  0);
        add(3, 0, 1, 0, 10'h000, 1, 0, 10'h066,  0);
        add(2, 0, 1, 0, 10'h000, 0, 1, 10'h066,  0);
        add(2, 1, 1, 0, 10'h123, 1, 0, 10'h123,  0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].ch, vecs[i].push, vecs[i].pop,
                          vecs[i].flush, vecs[i].din, 1);
            checkOutput($sformatf("vec%0d val", i),   32'(val),     32'(vecs[i].e_val));
            checkOutput($sformatf("vec%0d err", i),   32'(err),     32'(vecs[i].e_err));
            checkOutput($sformatf("vec%0d dout", i),  32'(dataout), 32'(vecs[i].e_dout));
            checkOutput($sformatf("vec%0d count", i), 32'(count),   32'(vecs[i].e_cnt));
            checkModel($sformatf("vec%0d", i));
        end
        checkOutput("passthru empty2", 32'(empty[2]), 32'd1);

        // Reset mid-operation aborts a pending pop
        applyStimulus(1, 1, 0, 0, 10'h101, 1);
        applyStimulus(1, 1, 0, 0, 10'h102, 1);
        applyStimulus(1, 1, 0, 0, 10'h103, 1);
        checkOutput("pre-reset count", 32'(count), 32'd3);
        applyStimulus(1, 0, 1, 0, '0, 0);
        checkOutput("midreset val",   32'(val),     32'd0);
        checkOutput("midreset count", 32'(count),   32'd0);
        checkOutput("midreset empty", 32'(empty),   32'hF);
        checkOutput("midreset full",  32'(full),    32'h0);
        checkOutput("midreset dout",  32'(dataout), 32'd0);
        applyStimulus(1, 0, 0, 0, '0, 1);
        checkModel("postreset");

        // Randomized phase against the model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int  c;
            bit  pu, po, fl, rn;
            c  = int'($urandom_range(0, CHANNELS - 1));
            fl = ($urandom_range(0, 99) < 4);
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            rn = ($urandom_range(0, 999) >= 5);
            applyStimulus(c, pu, po, fl, DATA_W'($urandom), rn);
            checkModel($sformatf("rand%0d", cyc));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
